// File: rtl/matriz_determ3x3_seq_if.sv
// Bus between the 3x3 determinant sequencer, its requester and the external 2x2 determinant unit.
// Every 8-bit field is unsigned and wraps mod 256.
interface matriz_determ3x3_seq_if;
  logic         start;
  logic [199:0] matriz_A;
  logic [199:0] minor_out;
  logic [7:0]   det_2x2;
  logic [7:0]   det;
  logic         busy;
  logic         done;
  logic [2:0]   dbg_state;

  // Handshake between requester and sequencer:
  // - start is accepted only in IDLE or DONE, on the rising edge where it is seen high.
  // - busy is high while a minor is being processed.
  // - done is high for exactly one cycle.
  // - det is valid from that cycle and holds until the next done.
  // - det_2x2 must settle combinationally from minor_out within one cycle.
  modport slave  (input  start, matriz_A, det_2x2,
                  output minor_out, det, busy, done, dbg_state);
  modport master (output start, matriz_A, det_2x2,
                  input  minor_out, det, busy, done, dbg_state);
endinterface

// File: rtl/matriz_determ3x3_seq.sv
// 3x3 determinant by cofactor expansion along row 0.
// Each of the three 2x2 minors is sent to an external 2x2 unit, one minor per cycle.
module matriz_determ3x3_seq (
  input  logic                       clk,
  input  logic                       rst_n,
  matriz_determ3x3_seq_if.slave      bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MINOR0 = 3'd1,
    MINOR1 = 3'd2,
    MINOR2 = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] m_q [3][3];
  logic [7:0] acc, det_q;
  logic [7:0] prod, acc_nxt;
  logic [1:0] kcol, ca, cb;
  logic       take, active, sub;

  // Only the top-left 3x3 bytes of the input matrix are used.
  logic unused_bits;
  assign unused_bits = ^{bus.matriz_A[199:104], bus.matriz_A[79:64], bus.matriz_A[39:24]};

  always_comb begin
    state_nxt     = state;
    take          = 1'b0;
    active        = 1'b0;
    sub           = 1'b0;
    kcol          = 2'd0;
    ca            = 2'd1;
    cb            = 2'd2;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.minor_out = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          take      = 1'b1;
          state_nxt = MINOR0;
        end
      end
      MINOR0: begin
        active    = 1'b1;
        kcol      = 2'd0;
        ca        = 2'd1;
        cb        = 2'd2;
        state_nxt = MINOR1;
      end
      MINOR1: begin
        active    = 1'b1;
        sub       = 1'b1;
        kcol      = 2'd1;
        ca        = 2'd0;
        cb        = 2'd2;
        state_nxt = MINOR2;
      end
      MINOR2: begin
        active    = 1'b1;
        kcol      = 2'd2;
        ca        = 2'd0;
        cb        = 2'd1;
        state_nxt = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          take      = 1'b1;
          state_nxt = MINOR0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (active) begin
      bus.busy             = 1'b1;
      bus.minor_out[7:0]   = m_q[1][ca];
      bus.minor_out[15:8]  = m_q[1][cb];
      bus.minor_out[47:40] = m_q[2][ca];
      bus.minor_out[55:48] = m_q[2][cb];
    end
  end

  // The middle cofactor carries the negative sign; the product keeps only its low 8 bits.
  assign prod    = m_q[0][kcol] * bus.det_2x2;
  assign acc_nxt = sub ? (acc - prod) : (acc + prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      det_q <= '0;
      m_q   <= '{default: '0};
    end else begin
      state <= state_nxt;
      if (take) begin
        acc <= '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            m_q[i][j] <= bus.matriz_A[i*40 + j*8 +: 8];
      end else if (active) begin
        acc <= acc_nxt;
      end
      if (state == MINOR2)
        det_q <= acc_nxt;
    end
  end

  assign bus.det       = det_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_matriz_determ3x3_seq.sv
// Self-checking bench for matriz_determ3x3_seq.
// A behavioural 2x2 unit and a cofactor-formula reference model for the 3x3 determinant.
module tb_matriz_determ3x3_seq;

  logic clk;
  logic rst_n;
  matriz_determ3x3_seq_if bus ();

  matriz_determ3x3_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external 2x2 determinant unit
  logic [7:0] q00, q01, q10, q11;
  assign q00 = bus.minor_out[7:0];
  assign q01 = bus.minor_out[15:8];
  assign q10 = bus.minor_out[47:40];
  assign q11 = bus.minor_out[55:48];
  assign bus.det_2x2 = (q00 * q11) - (q10 * q01);

  int n_vec = 0;
  int n_err = 0;
  int spurious = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [199:0] mk3(input logic [23:0] r0, input logic [23:0] r1,
                                       input logic [23:0] r2, input logic [7:0] pad);
    logic [199:0] m;
    logic [23:0] rows [3];
    rows[0] = r0; rows[1] = r1; rows[2] = r2;
    for (int b = 0; b < 25; b++) m[b*8 +: 8] = pad;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[i*40 + j*8 +: 8] = rows[i][23 - j*8 -: 8];
    return m;
  endfunction

  function automatic logic [7:0] det3(input logic [199:0] m);
    int a [3][3];
    int d;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        a[i][j] = int'(m[i*40 + j*8 +: 8]);
    d = a[0][0] * (a[1][1]*a[2][2] - a[1][2]*a[2][1])
      - a[0][1] * (a[1][0]*a[2][2] - a[1][2]*a[2][0])
      + a[0][2] * (a[1][0]*a[2][1] - a[1][1]*a[2][0]);
    return d[7:0];
  endfunction

  function automatic logic [199:0] minor_of(input logic [199:0] m, input int k);
    logic [199:0] r;
    int c [2];
    int n;
    r = '0;
    n = 0;
    for (int col = 0; col < 3; col++)
      if (col != k) begin
        c[n] = col;
        n++;
      end
    r[7:0]   = m[40 + c[0]*8 +: 8];
    r[15:8]  = m[40 + c[1]*8 +: 8];
    r[47:40] = m[80 + c[0]*8 +: 8];
    r[55:48] = m[80 + c[1]*8 +: 8];
    return r;
  endfunction

  function automatic logic [199:0] rnd200();
    logic [199:0] r;
    for (int b = 0; b < 25; b++) r[b*8 +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic logic [199:0] rnd_mat();
    return mk3(24'($urandom), 24'($urandom), 24'($urandom), 8'($urandom));
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) spurious++;
      else check("det", bus.det, exp_q.pop_front());
    end
  end

  // driver tasks
  // Caller is at a negedge; the next rising edge samples start.
  task automatic run_body(input logic [199:0] mat);
    bus.start    = 1'b1;
    bus.matriz_A = mat;
    exp_q.push_back(det3(mat));
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.matriz_A = rnd200();
      check($sformatf("busy_minor%0d", k), bus.busy, 1'b1);
      check($sformatf("done_minor%0d", k), bus.done, 1'b0);
      check($sformatf("minor_out%0d", k), bus.minor_out, minor_of(mat, k));
      @(negedge clk);
    end
    check("done_pulse", bus.done, 1'b1);
    check("busy_in_done", bus.busy, 1'b0);
    check("minor_in_done", bus.minor_out, '0);
    @(negedge clk);
    check("done_low_after", bus.done, 1'b0);
    check("busy_idle", bus.busy, 1'b0);
  endtask

  task automatic run_single(input logic [199:0] mat);
    @(negedge clk);
    run_body(mat);
  endtask

  logic [199:0] gen_m;

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.matriz_A = '0;
    gen_m        = mk3(24'h010203, 24'h040506, 24'h07080A, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_det", bus.det, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_minor", bus.minor_out, '0);
    check("rst_state", bus.dbg_state, 3'd0);
    rst_n = 1'b1;

    // directed cases
    run_single(mk3(24'h010000, 24'h000100, 24'h000001, 8'h00));
    check("identity_det", bus.det, 8'h01);
    run_single(gen_m);
    check("general_det", bus.det, 8'hFD);
    run_single(mk3(24'h100000, 24'h001000, 24'h000001, 8'h00));
    check("wrap_det", bus.det, 8'h00);
    run_single(gen_m);
    run_single(mk3(24'h100000, 24'h001000, 24'h000001, 8'hFF));
    check("wrap_pad_det", bus.det, 8'h00);

    // randomized
    for (int t = 0; t < 20; t++) run_single(rnd_mat());

    // back-to-back with start held high and the matrix changing every cycle
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      check($sformatf("b2b_done%0d", cyc), bus.done, (cyc > 0 && cyc % 4 == 0));
      check($sformatf("b2b_busy%0d", cyc), bus.busy, (cyc > 0 && cyc % 4 != 0));
      bus.start    = 1'b1;
      bus.matriz_A = rnd_mat();
      if (cyc % 4 == 0) exp_q.push_back(det3(bus.matriz_A));
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_last_done", bus.done, 1'b1);
    @(negedge clk);
    check("b2b_idle", bus.busy, 1'b0);

    // reset mid-operation
    run_single(gen_m);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.matriz_A = rnd_mat();
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_det", bus.det, 8'h00);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_minor", bus.minor_out, '0);
    check("midrst_state", bus.dbg_state, 3'd0);
    repeat (2) @(negedge clk);
    check("rst_hold_det", bus.det, 8'h00);
    rst_n = 1'b1;
    run_body(gen_m);
    check("post_rst_det", bus.det, 8'hFD);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("no_spurious_done", spurious, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matriz_determ3x3_seq.md
MATRIZ_DETERM3X3_SEQ -- requirements
Module: matriz_determ3x3_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to compute a determinant; sampled on the clk rising edge.
REQ-005 SHALL have port matriz_A, input, 200 bits: 5x5 byte matrix, element [i][j] at bits i*40+j*8 +: 8; only [0..2][0..2] are used.
REQ-006 SHALL have port minor_out, output, 200 bits: 2x2 minor packed in the same 5x5 layout; drives the downstream 2x2 determinant unit.
REQ-007 SHALL have port det_2x2, input, 8 bits: combinational result from the 2x2 unit, m[0][0]*m[1][1] - m[1][0]*m[0][1] mod 256.
REQ-008 SHALL have port det, output, 8 bits: 3x3 determinant result, mod 256.
REQ-009 SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when det is updated.

Function
REQ-011 SHALL implement the states IDLE, MINOR0, MINOR1, MINOR2 and DONE.
REQ-012 In IDLE with start=1, SHALL capture matriz_A into an internal register, clear the accumulator, and go to MINOR0 on the same edge.
REQ-013 SHALL ignore start in every state except IDLE and DONE; later changes to matriz_A SHALL NOT affect the computation in progress.
REQ-014 In MINORk (k=0,1,2), SHALL drive minor_out[0][0], [0][1], [1][0] and [1][1] from rows 1 and 2 of the captured matrix, excluding column k, in ascending column order.
- Example: MINOR0 drives m[1][1], m[1][2], m[2][1], m[2][2].
- All other 21 bytes of minor_out SHALL be 0.
REQ-015 In MINORk, SHALL sample det_2x2 on the same edge and update acc with (acc + s_k * m[0][k] * det_2x2) mod 256.
- s_k = +1 for k=0 and k=2; s_k = -1 for k=1.
- Each product SHALL be truncated to 8 bits.
REQ-016 SHALL make the transitions MINOR0->MINOR1->MINOR2->DONE unconditionally, one cycle each.
REQ-017 On entering DONE, SHALL load the final acc into det; done=1 for exactly the DONE cycle.
REQ-018 From DONE, SHALL go to IDLE, or directly to MINOR0 (with a fresh capture) if start=1.
REQ-019 Latency SHALL be as follows: with start sampled at edge E, done is high in the cycle after edge E+3, and det is valid from that cycle.
REQ-020 det SHALL hold its value until the next DONE entry.
REQ-021 busy SHALL be 1 in MINOR0 to MINOR2 and 0 in IDLE and DONE.
REQ-022 minor_out SHALL be all zeros in IDLE and DONE.
REQ-023 All arithmetic SHALL be unsigned mod 256; two's-complement interpretation of det is left to the consumer.

Reset
REQ-024 When rst_n=0, SHALL immediately (asynchronously) force the state to IDLE, det=0, done=0, busy=0, minor_out=0, the accumulator to 0 and the captured matrix to 0.
REQ-025 SHALL abort any computation in progress on reset mid-operation, with no done pulse.
REQ-026 After rst_n rises, SHALL accept start on the first rising edge.

Verification
REQ-027 Identity: rows [1,0,0],[0,1,0],[0,0,1] with a start pulse -> busy for 3 cycles, done pulse, det=0x01.
REQ-028 General: rows [1,2,3],[4,5,6],[7,8,10] -> det=0xFD (-3).
- minor_out in MINOR1 holds bytes 4,6,7,10 at positions [0][0],[0][1],[1][0],[1][1].
REQ-029 Wrap-around: rows [16,0,0],[0,16,0],[0,0,1] -> det=0x00.
- Rows 3-4 and columns 3-4 filled with 0xFF -> det is unchanged.
REQ-030 Busy and back-to-back: start held high continuously, matriz_A changed mid-run -> starts pulsed during MINOR states are ignored.
- Results match the matrices captured at IDLE/DONE, one done every 4 cycles.
REQ-031 Reset mid-operation: rst_n low during MINOR1 -> all outputs 0 immediately and no done pulse.
- A new start after release yields the correct det.
